// File: rtl/cpu_uart_top.sv
// Boot loader that streams a program image into imem, then a
// single-cycle RV32I-subset core that executes out of it.

module cpu_uart_rf (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] write_data,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  logic [31:0] regs [32];

  // x0 is never written, so it reads back as its reset value 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= write_data;
    end
  end

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];
endmodule

module cpu_uart_top #(
  parameter int          CELL_NUMBERS = 16,
  parameter string       BOOT_FILE    = "program.hex",
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] alu_result,
  output logic [31:0] pc
);
  localparam int AW = $clog2(CELL_NUMBERS);

  typedef enum logic {LOAD, RUN} mode_t;

  mode_t         mode;
  mode_t         mode_nxt;
  logic [AW-1:0] cnt;
  logic          last;
  logic [31:0]   boot [CELL_NUMBERS];
  logic [31:0]   imem [CELL_NUMBERS];

  logic [31:0] instr;
  logic [6:0]  opc;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  f3;
  logic        is_r;
  logic        is_i;
  logic        is_lui;
  logic        is_br;
  logic        is_jal;
  logic        is_alu;
  logic [31:0] imm_i;
  logic [31:0] imm_b;
  logic [31:0] imm_j;
  logic [31:0] imm_u;
  logic [31:0] rs1_v;
  logic [31:0] rs2_v;
  logic [31:0] op_b;
  logic [4:0]  shamt;
  logic [31:0] sra_v;
  logic [31:0] alu;
  logic        taken;
  logic        we;
  logic        wen;
  logic [31:0] write_data;
  logic [31:0] pc_nxt;

  assign last = (cnt == AW'(CELL_NUMBERS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode <= LOAD;
      cnt  <= '0;
    end else begin
      mode <= mode_nxt;
      if (mode == LOAD) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    mode_nxt = mode;
    unique case (mode)
      LOAD: if (last) mode_nxt = RUN;
      RUN:  mode_nxt = RUN;
    endcase
  end

  // imem has no reset: the loader overwrites every word before RUN
  always_ff @(posedge clk) begin
    if (mode == LOAD) imem[cnt] <= boot[cnt];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= RESET_PC;
    else if (mode == RUN) pc <= pc_nxt;
  end

  assign instr = imem[pc[AW+1:2]];
  assign opc   = instr[6:0];
  assign rd    = instr[11:7];
  assign f3    = instr[14:12];
  assign rs1   = instr[19:15];
  assign rs2   = instr[24:20];

  assign is_r   = (opc == 7'h33);
  assign is_i   = (opc == 7'h13);
  assign is_lui = (opc == 7'h37);
  assign is_br  = (opc == 7'h63);
  assign is_jal = (opc == 7'h6f);
  assign is_alu = is_r | is_i;

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_b = {{20{instr[31]}}, instr[7],
                  instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{12{instr[31]}}, instr[19:12],
                  instr[20], instr[30:21], 1'b0};
  assign imm_u = {instr[31:12], 12'h000};

  cpu_uart_rf rf (
    .clk        (clk),
    .rst        (rst),
    .we         (wen),
    .waddr      (rd),
    .write_data (write_data),
    .raddr1     (rs1),
    .raddr2     (rs2),
    .rdata1     (rs1_v),
    .rdata2     (rs2_v)
  );

  assign op_b  = is_r ? rs2_v : imm_i;
  assign shamt = op_b[4:0];
  // kept apart so the arithmetic shift is not forced unsigned
  assign sra_v = $signed(rs1_v) >>> shamt;

  always_comb begin
    alu = '0;
    unique case (f3)
      3'd0: alu = (is_r && instr[30]) ? rs1_v - op_b
                                       : rs1_v + op_b;
      3'd1: alu = rs1_v << shamt;
      3'd2: alu = {31'b0, $signed(rs1_v) < $signed(op_b)};
      3'd3: alu = {31'b0, rs1_v < op_b};
      3'd4: alu = rs1_v ^ op_b;
      3'd5: alu = instr[30] ? sra_v : rs1_v >> shamt;
      3'd6: alu = rs1_v | op_b;
      3'd7: alu = rs1_v & op_b;
    endcase
  end

  assign taken = (f3 == 3'd0 && rs1_v == rs2_v) ||
                 (f3 == 3'd1 && rs1_v != rs2_v);

  always_comb begin
    pc_nxt     = pc + 32'd4;
    write_data = alu;
    we         = 1'b0;
    unique case (1'b1)
      is_jal: begin
        pc_nxt     = pc + imm_j;
        write_data = pc + 32'd4;
        we         = 1'b1;
      end
      is_lui: begin
        write_data = imm_u;
        we         = 1'b1;
      end
      is_br:  if (taken) pc_nxt = pc + imm_b;
      is_alu: we = 1'b1;
      default: ;
    endcase
  end

  assign wen        = we && (mode == RUN);
  assign alu_result = (mode == RUN) ? alu : '0;
endmodule

// File: tb/tb_cpu_uart_top.sv
// Scoreboard bench for cpu_uart_top: an ISA-level model predicts the
// per-cycle pc/alu/write_data trace and final register contents.

module tb_cpu_uart_top;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] alu_result;
  logic [31:0] pc;

  cpu_uart_top #(
    .CELL_NUMBERS (N),
    .BOOT_FILE    (""),
    .RESET_PC     (32'h0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_result (alu_result),
    .pc         (pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] wd;
    bit          chk_alu;
    bit          chk_wd;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_chk;
  int          n_pass;
  logic [31:0] prog   [N];
  logic [31:0] mregs  [32];
  logic [31:0] mpc;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7,
    input logic [4:0] rs2, input logic [4:0] rs1,
    input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm,
    input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm,
    input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm,
    input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [11:0] imm;
    int          off;
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    f3  = 3'($urandom_range(0, 7));
    imm = 12'($urandom);
    case ($urandom_range(0, 9))
      0, 1, 2: begin
        return enc_r(((f3 == 3'd0 || f3 == 3'd5) &&
                      $urandom_range(0, 1) != 0) ? 7'h20 : 7'h00,
                     rs2, rs1, f3, rd);
      end
      3, 4, 5: begin
        if (f3 == 3'd1) imm = {7'h00, imm[4:0]};
        else if (f3 == 3'd5)
          imm = {($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, imm[4:0]};
        return enc_i(imm, rs1, f3, rd);
      end
      6: return {20'($urandom), rd, 7'h37};
      7: begin
        off = int'(4 * $urandom_range(0, 6)) - 8;
        return enc_b(13'(off), rs2, rs1, {2'b00, 1'($urandom_range(0, 1))});
      end
      8: begin
        off = int'(4 * $urandom_range(0, 8)) - 16;
        return enc_j(21'(off), rd);
      end
      default: return {25'($urandom), 7'h03};
    endcase
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] f3,
    input bit alt, input bit is_r, input logic [31:0] a,
    input logic [31:0] b);
    logic [31:0] ones;
    logic [4:0]  sh;
    ones = 32'hFFFF_FFFF;
    sh   = b[4:0];
    case (f3)
      3'd0: return (is_r && alt) ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? ((a >> sh) | (a[31] ? ~(ones >> sh) : 32'd0))
                       : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic m_reset();
    for (int r = 0; r < 32; r++) mregs[r] = '0;
    mpc = 32'h0;
  endtask

  task automatic m_step(output exp_t e);
    logic [31:0] ins;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] npc;
    logic [2:0]  f3;
    logic [4:0]  rd;
    bit          w;
    ins = prog[(mpc >> 2) % N];
    a   = mregs[ins[19:15]];
    b   = mregs[ins[24:20]];
    f3  = ins[14:12];
    rd  = ins[11:7];
    npc = mpc + 32'd4;
    w   = 1'b0;
    e.pc = mpc; e.alu = '0; e.wd = '0; e.chk_alu = 1'b0; e.chk_wd = 1'b0;
    case (ins[6:0])
      7'h33: begin
        e.alu = ref_alu(f3, ins[30], 1'b1, a, b);
        e.chk_alu = 1'b1; e.wd = e.alu; w = 1'b1;
      end
      7'h13: begin
        e.alu = ref_alu(f3, ins[30], 1'b0, a, 32'($signed(ins[31:20])));
        e.chk_alu = 1'b1; e.wd = e.alu; w = 1'b1;
      end
      7'h37: begin
        e.wd = {ins[31:12], 12'h000}; w = 1'b1;
      end
      7'h6f: begin
        e.wd = mpc + 32'd4; w = 1'b1;
        npc = mpc + 32'($signed({ins[31], ins[19:12], ins[20],
                                 ins[30:21], 1'b0}));
      end
      7'h63: begin
        if ((f3 == 3'd0 && a == b) || (f3 == 3'd1 && a != b))
          npc = mpc + 32'($signed({ins[31], ins[7], ins[30:25],
                                   ins[11:8], 1'b0}));
      end
      default: ;
    endcase
    e.chk_wd = w;
    if (w && rd != 5'd0) mregs[rd] = e.wd;
    mpc = npc;
  endtask

  always @(negedge clk) begin
    if (!rst && sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk($sformatf("trace_pc@%0h", mon_e.pc), pc, mon_e.pc);
      if (mon_e.chk_alu)
        chk($sformatf("trace_alu@%0h", mon_e.pc), alu_result, mon_e.alu);
      if (mon_e.chk_wd)
        chk($sformatf("trace_wd@%0h", mon_e.pc), dut.rf.write_data, mon_e.wd);
    end
  end

  function automatic logic [31:0] regs_or();
    logic [31:0] v;
    v = '0;
    for (int r = 0; r < 32; r++) v |= dut.rf.regs[r];
    return v;
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < N; i++) prog[i] = 32'h0;
  endtask

  task automatic run_prog(input int steps, input bit mid_reset);
    exp_t e;
    int   t;
    rst = 1'b1;
    for (int i = 0; i < N; i++) dut.boot[i] = prog[i];
    repeat (5) begin
      @(negedge clk);
      chk("reset_pc", pc, 32'h0);
      chk("reset_alu", alu_result, 32'h0);
      chk("reset_regs", regs_or(), 32'h0);
    end
    m_reset();
    for (int i = 0; i < N - 1; i++) begin
      e.pc = 32'h0; e.alu = 32'h0; e.wd = 32'h0;
      e.chk_alu = 1'b1; e.chk_wd = 1'b0;
      sb.push_back(e);
    end
    for (int s = 0; s < steps; s++) begin
      m_step(e);
      sb.push_back(e);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    t = 0;
    while (sb.size() != 0 && t < N + steps + 8) begin
      @(posedge clk);
      t++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
    sb.delete();
    #1;
    if (mid_reset) begin
      #2 rst = 1'b1;
      #1;
      chk("async_pc", pc, 32'h0);
      chk("async_alu", alu_result, 32'h0);
      chk("async_regs", regs_or(), 32'h0);
    end else begin
      for (int r = 1; r < 32; r++)
        chk($sformatf("reg_x%0d", r), dut.rf.regs[r], mregs[r]);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_pass = 0;
    #1;

    clear_prog();
    prog[0] = enc_i(12'd1, 5'd0, 3'd0, 5'd1);
    prog[1] = enc_i(12'd3, 5'd0, 3'd0, 5'd2);
    prog[2] = enc_r(7'h00, 5'd2, 5'd1, 3'd1, 5'd3);
    run_prog(3, 1'b0);
    chk("sll_x3", dut.rf.regs[3], 32'h8);
    chk("sll_pc", pc, 32'd12);

    clear_prog();
    prog[0] = enc_i(12'hFF8, 5'd0, 3'd0, 5'd1);
    prog[1] = enc_i({7'h20, 5'd1}, 5'd1, 3'd5, 5'd2);
    prog[2] = enc_i({7'h00, 5'd28}, 5'd1, 3'd5, 5'd3);
    run_prog(3, 1'b0);
    chk("srai_x2", dut.rf.regs[2], 32'hFFFF_FFFC);
    chk("srli_x3", dut.rf.regs[3], 32'h0000_000F);

    clear_prog();
    prog[0] = enc_i(12'd5, 5'd0, 3'd0, 5'd1);
    prog[1] = enc_b(13'd8, 5'd0, 5'd1, 3'd1);
    prog[2] = enc_i(12'd1, 5'd0, 3'd0, 5'd2);
    prog[3] = enc_i(12'd2, 5'd0, 3'd0, 5'd3);
    run_prog(3, 1'b0);
    chk("bne_x2", dut.rf.regs[2], 32'h0);
    chk("bne_x3", dut.rf.regs[3], 32'h2);
    chk("bne_pc", pc, 32'd16);

    clear_prog();
    prog[0] = enc_j(21'd8, 5'd1);
    prog[1] = enc_i(12'd9, 5'd0, 3'd0, 5'd5);
    prog[2] = enc_i(12'd7, 5'd0, 3'd0, 5'd0);
    run_prog(2, 1'b0);
    chk("jal_x1", dut.rf.regs[1], 32'h4);
    chk("jal_x5", dut.rf.regs[5], 32'h0);
    chk("x0_zero", dut.rf.regs[0], 32'h0);
    chk("jal_pc", pc, 32'd12);

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) prog[i] = rnd_instr();
      if (k == 0) run_prog(6, 1'b1);
      run_prog(24, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
